// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises core fetches and load/store requests onto a byte-wide RAM/IO bus,
// assembles little-endian read data with sign/zero extension, and stalls IO stores while
// the IO buffer is full.
module mem_ctrl #(
  parameter logic [31:0] IO_BOUNDARY = 32'h30000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  input  logic        flush_in,
  input  logic        ls_valid,
  input  logic        ls_wr,
  input  logic [2:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_value,
  output logic        ls_ready,
  output logic [31:0] ls_res
);

  typedef enum logic [1:0] {StIdle, StLsRd, StLsWr, StIfRd} state_e;

  state_e      state;
  logic [2:0]  cnt;      // bytes issued on the bus
  logic [2:0]  got;      // bytes captured from mem_din
  logic [2:0]  n;        // bytes in this access: 1, 2 or 4
  logic [2:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] buffer;
  logic        armed;    // set once read data starts arriving (second edge after accept)

  logic [31:0] rd_word;
  logic [31:0] ld_ext;
  logic [2:0]  req_n;
  logic        req_io_stall;
  logic        io_stall;

  // Byte count of the incoming request and IO-stall conditions for accept and for retries
  always_comb begin
    req_n = 3'd4;
    if (ls_size[1:0] == 2'd0) begin
      req_n = 3'd1;
    end else if (ls_size[1:0] == 2'd1) begin
      req_n = 3'd2;
    end
    req_io_stall = (ls_addr >= IO_BOUNDARY) && io_buffer_full;
    io_stall     = (addr >= IO_BOUNDARY) && io_buffer_full;
  end

  // Read word including the byte arriving this cycle, then extension by access size
  always_comb begin
    rd_word = buffer;
    rd_word[{got[1:0], 3'b000} +: 8] = mem_din;
    case (size[1:0])
      2'd0:    ld_ext = size[2] ? {24'b0, rd_word[7:0]} : {{24{rd_word[7]}}, rd_word[7:0]};
      2'd1:    ld_ext = size[2] ? {16'b0, rd_word[15:0]} : {{16{rd_word[15]}}, rd_word[15:0]};
      default: ld_ext = rd_word;
    endcase
  end

  // Controller FSM with registered bus and result outputs; rdy_in low freezes everything
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= StIdle;
      cnt      <= 3'd0;
      got      <= 3'd0;
      n        <= 3'd0;
      size     <= 3'd0;
      addr     <= 32'd0;
      wdata    <= 32'd0;
      buffer   <= 32'd0;
      armed    <= 1'b0;
      mem_a    <= 32'd0;
      mem_dout <= 8'd0;
      mem_wr   <= 1'b0;
      if_ready <= 1'b0;
      ls_ready <= 1'b0;
      if_data  <= 32'd0;
      ls_res   <= 32'd0;
    end else if (rdy_in) begin
      if_ready <= 1'b0;
      ls_ready <= 1'b0;
      unique case (state)
        StIdle: begin
          // The requester's valid may still belong to the access that just completed
          if (!ls_ready && !if_ready) begin
            if (ls_valid) begin
              addr  <= ls_addr;
              wdata <= ls_value;
              size  <= ls_size;
              n     <= req_n;
              got   <= 3'd0;
              armed <= 1'b0;
              mem_a <= ls_addr;
              if (ls_wr) begin
                state <= StLsWr;
                if (req_io_stall) begin
                  cnt    <= 3'd0;
                  mem_wr <= 1'b0;
                end else begin
                  cnt      <= 3'd1;
                  mem_wr   <= 1'b1;
                  mem_dout <= ls_value[7:0];
                end
              end else begin
                state <= StLsRd;
                cnt   <= 3'd1;
              end
            end else if (if_valid && !flush_in) begin
              state <= StIfRd;
              addr  <= if_addr;
              size  <= 3'b010;
              n     <= 3'd4;
              cnt   <= 3'd1;
              got   <= 3'd0;
              armed <= 1'b0;
              mem_a <= if_addr;
            end
          end
        end
        StLsRd, StIfRd: begin
          if (state == StIfRd && flush_in) begin
            state <= StIdle;
            mem_a <= 32'd0;
          end else begin
            if (cnt < n) begin
              mem_a <= addr + {29'b0, cnt};
              cnt   <= cnt + 3'd1;
            end
            if (armed) begin
              buffer <= rd_word;
              got    <= got + 3'd1;
              if (got == n - 3'd1) begin
                if (state == StIfRd) begin
                  if_data  <= rd_word;
                  if_ready <= 1'b1;
                end else begin
                  ls_res   <= ld_ext;
                  ls_ready <= 1'b1;
                end
                state <= StIdle;
                mem_a <= 32'd0;
              end
            end
            armed <= 1'b1;
          end
        end
        StLsWr: begin
          if (cnt == n) begin
            mem_wr   <= 1'b0;
            ls_ready <= 1'b1;
            ls_res   <= 32'd0;
            state    <= StIdle;
            mem_a    <= 32'd0;
          end else if (io_stall) begin
            mem_wr <= 1'b0;
          end else begin
            mem_a    <= addr + {29'b0, cnt};
            mem_dout <= wdata[{cnt[1:0], 3'b000} +: 8];
            mem_wr   <= 1'b1;
            cnt      <= cnt + 3'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
